count_match_ctrl: RTL
=====================

Name: count_match_ctrl

Overview:
Compare-and-clear controller on the consumer side of the free-running event counter. It watches the counter's DATA_WIDTH-bit value and, when the value reaches a programmed limit, issues a one-cycle clear pulse that drives the counter's compare-reset input. It then waits for the counter to read zero and re-arms. It also keeps a saturating count of matches and flags a fault if the counter fails to clear.

Parameters:
DATA_WIDTH, 32, width of observed count and of limit register
MATCH_CNT_WIDTH, 16, width of match event counter
HOLDOFF_CYCLES, 8, max cycles to wait for count==0 after a clear pulse before fault

Ports:
clock  input  1  single clock; all logic on its rising edge
i_reset  input  1  synchronous, active-high reset
i_count_data  input  DATA_WIDTH  current counter value being observed
i_limit  input  DATA_WIDTH  limit value, captured on i_load
i_load  input  1  capture i_limit into the limit register this cycle
i_enable  input  1  level; 1 = run compare, 0 = go/stay idle
i_clear_fault  input  1  pulse; leave FAULT state
o_comp_reset  output  1  one-cycle clear pulse to counter compare-reset input
o_match  output  1  one-cycle match strobe, coincident with o_comp_reset
o_match_count  output  MATCH_CNT_WIDTH  saturating number of matches since reset
o_cfg_err  output  1  sticky; last load attempted limit==0
o_fault  output  1  high while in FAULT
o_armed  output  1  high while in ARMED

Behaviour:
- Interface: single clock `clock`; reset `i_reset` is synchronous and active-high, sampled only on the rising edge of `clock`.
- Reset: state=IDLE; limit register=0 (invalid); o_comp_reset=0, o_match=0, o_match_count=0, o_cfg_err=0, o_fault=0, o_armed=0. i_reset has priority over every other input.
- Limit load: accepted in any state except FAULT.
  - i_limit!=0: limit register is written and o_cfg_err is cleared.
  - i_limit==0: the limit register is unchanged and o_cfg_err=1.
  - A new limit takes effect on the cycle after the load.
- States: IDLE, ARMED, HOLDOFF, FAULT. All outputs are registered.
- IDLE: if i_enable=1 and limit!=0, go to ARMED next cycle.
- ARMED:
  - If i_enable=0, go to IDLE.
  - Else if i_count_data >= limit (unsigned, full DATA_WIDTH), go to HOLDOFF. In the next cycle o_comp_reset=1 and o_match=1 for exactly one cycle, and o_match_count increments, saturating at all-ones.
  - Latency: count sampled at edge N gives the pulse asserted after edge N+1, one cycle wide.
- HOLDOFF: the timer starts at 0 when the state is entered.
  - If i_count_data==0, go to ARMED (i_enable=1) or IDLE (i_enable=0).
  - Else if the timer reaches HOLDOFF_CYCLES, go to FAULT.
  - Otherwise the timer increments.
  - No match is evaluated in HOLDOFF, and i_enable=0 does not abort it.
- FAULT: o_fault=1. A pulse on i_clear_fault moves to IDLE. i_load is ignored.
- Boundary cases:
  - A load in the same cycle as a match: the match uses the old limit.
  - limit equal to all-ones: a match occurs only at count==all-ones.
  - Count already >= limit when entering ARMED: match on the first ARMED cycle.
  - Counter wraps past the limit without it being seen (not possible while i_count_data increments by at most 1 per cycle): not detected. The >= compare covers any skipped value.
  - o_comp_reset is never high for two consecutive cycles.

Decomposition:
- Shared package count_match_pkg holds:
  - state encoding constants ST_IDLE, ST_ARMED, ST_HOLDOFF, ST_FAULT (2 bits);
  - default widths;
  - holdoff timer width, clog2(HOLDOFF_CYCLES+1).
- One sub-module, match_event_counter: parameterised-width saturating incrementer with synchronous reset, driving o_match_count.

Test Plan:
- Reset, load 5, enable, count ramps 0..5 -> o_comp_reset/o_match high for one cycle, the cycle after count=5 is sampled; o_match_count=1; count returns 0 -> o_armed=1 again.
- Load 0 -> o_cfg_err=1, state stays IDLE with enable=1; then load 3 -> o_cfg_err=0 and ARMED next cycle.
- HOLDOFF_CYCLES=8, count held at 7 after the clear pulse -> o_fault=1 on the 9th HOLDOFF cycle; i_load ignored in FAULT; i_clear_fault -> IDLE.
- MATCH_CNT_WIDTH=2, force 5 matches -> o_match_count sequence 1,2,3,3,3.
- Load 10 in the same cycle count=4 >= old limit 4 -> match fires, and the next match requires count>=10.
- i_reset asserted in HOLDOFF with count=9 -> next cycle all outputs are at reset values and state is IDLE.

Source files
------------

// File: rtl/count_match_pkg.sv
// Shared types and constants for the count/match controller.
// State encoding, default widths and holdoff timer sizing.
package count_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_MATCH_CNT_WIDTH = 16;
    localparam int DEF_HOLDOFF_CYCLES  = 8;

    // Timer must be able to hold the value HOLDOFF_CYCLES itself.
    function automatic int holdoff_timer_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/match_event_counter.sv
// Saturating event counter with synchronous active-high reset.
// Sticks at all-ones once reached.
module match_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    // Count increment requests, holding at the maximum value.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/count_match_ctrl.sv
// Compare-and-clear controller for a free-running event counter.
// Pulses a clear on limit match, waits for zero, re-arms or faults.
module count_match_ctrl
    import count_match_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MATCH_CNT_WIDTH = DEF_MATCH_CNT_WIDTH,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic [DATA_WIDTH-1:0]      i_count_data,
    input  logic [DATA_WIDTH-1:0]      i_limit,
    input  logic                       i_load,
    input  logic                       i_enable,
    input  logic                       i_clear_fault,
    output logic                       o_comp_reset,
    output logic                       o_match,
    output logic [MATCH_CNT_WIDTH-1:0] o_match_count,
    output logic                       o_cfg_err,
    output logic                       o_fault,
    output logic                       o_armed
);

    localparam int TW = holdoff_timer_width(HOLDOFF_CYCLES);
    localparam logic [TW-1:0] HOLD_MAX = TW'(HOLDOFF_CYCLES);

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] limit;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_next;
    logic                  pulse_next;
    logic                  load_ok;

    assign load_ok = i_load && (state != ST_FAULT);

    // Limit register; a zero limit is rejected and flagged instead.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            limit     <= '0;
            o_cfg_err <= 1'b0;
        end else if (load_ok) begin
            if (i_limit != '0) begin
                limit     <= i_limit;
                o_cfg_err <= 1'b0;
            end else begin
                o_cfg_err <= 1'b1;
            end
        end
    end

    // Next-state, holdoff timer and clear-pulse decision.
    always_comb begin
        state_next = state;
        timer_next = timer;
        pulse_next = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_enable && (limit != '0)) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!i_enable) begin
                    state_next = ST_IDLE;
                end else if (i_count_data >= limit) begin
                    state_next = ST_HOLDOFF;
                    timer_next = '0;
                    pulse_next = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (i_count_data == '0) begin
                    state_next = i_enable ? ST_ARMED : ST_IDLE;
                end else if (timer == HOLD_MAX) begin
                    state_next = ST_FAULT;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ST_FAULT: begin
                if (i_clear_fault) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, timer and registered status outputs.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            o_comp_reset <= 1'b0;
            o_match      <= 1'b0;
            o_fault      <= 1'b0;
            o_armed      <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            o_comp_reset <= pulse_next;
            o_match      <= pulse_next;
            o_fault      <= (state_next == ST_FAULT);
            o_armed      <= (state_next == ST_ARMED);
        end
    end

    match_event_counter #(
        .WIDTH (MATCH_CNT_WIDTH)
    ) u_match_cnt (
        .clock   (clock),
        .i_reset (i_reset),
        .i_inc   (pulse_next),
        .o_count (o_match_count)
    );

endmodule
